// File: rtl/vending_machine_multi_if.sv
// Button and status bundle of the multi-product vending machine.
//   master : drives the raw active-low buttons, coin value and price table,
//            and observes the machine outputs.
//   slave  : the vending machine itself.
// Signals:
//   coin_ni, amount_ni, sel_ni, cancel_ni : active-low buttons / coin value
//   prices_i                              : packed price table, product k at [k*W +: W]
//   dispense_o                            : one-hot dispense strobe
//   credit_o                              : accumulated credit
//   change_o, change_valid_o              : change value and its strobe
//   reject_o, short_o, busy_o             : coin refused / credit too low / vending
interface vending_machine_multi_if #(
    parameter int W      = 8,
    parameter int N_PROD = 4
);
    logic                  coin_ni;
    logic [W-1:0]          amount_ni;
    logic [N_PROD-1:0]     sel_ni;
    logic                  cancel_ni;
    logic [N_PROD*W-1:0]   prices_i;
    logic [N_PROD-1:0]     dispense_o;
    logic [W-1:0]          credit_o;
    logic [W-1:0]          change_o;
    logic                  change_valid_o;
    logic                  reject_o;
    logic                  short_o;
    logic                  busy_o;

    modport master (
        output coin_ni, amount_ni, sel_ni, cancel_ni, prices_i,
        input  dispense_o, credit_o, change_o, change_valid_o, reject_o, short_o, busy_o
    );

    modport slave (
        input  coin_ni, amount_ni, sel_ni, cancel_ni, prices_i,
        output dispense_o, credit_o, change_o, change_valid_o, reject_o, short_o, busy_o
    );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-product vending machine controller.
// Every button is synchronized and debounced; a released-to-pressed
// transition of the debounced level makes a one-cycle press event that
// drives a four-state FSM (IDLE, ACCUM, VEND, CHANGE).
// Ports:
//   clk_i  : system clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : button inputs, price table and machine outputs (slave side)
module vending_machine_multi #(
    parameter int W               = 8,
    parameter int N_PROD          = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int DISP_CYCLES     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    vending_machine_multi_if.slave bus
);
    localparam int NB  = N_PROD + 2;
    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DCW = $clog2(DISP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;

    // Bit 0 coin, bits 1..N_PROD selects, top bit cancel.
    logic [NB-1:0] btn_n;
    logic [NB-1:0] press_ev;
    assign btn_n = {bus.cancel_ni, bus.sel_ni, bus.coin_ni};

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : gen_btn
            logic [1:0]    sync_reg;
            logic          level_reg;
            logic [CW-1:0] cnt_reg;
            logic          ev_reg;

            // The counter runs only while the synchronized sample disagrees
            // with the accepted level; any agreeing sample restarts it.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync_reg  <= 2'b11;
                    level_reg <= 1'b1;
                    cnt_reg   <= '0;
                    ev_reg    <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[0], btn_n[gi]};
                    ev_reg   <= 1'b0;
                    if (sync_reg[1] == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                        level_reg <= sync_reg[1];
                        cnt_reg   <= '0;
                        ev_reg    <= ~sync_reg[1];
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press_ev[gi] = ev_reg;
        end
    endgenerate

    logic [W-1:0] amt_sync1_reg, amt_sync2_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            amt_sync1_reg <= '1;
            amt_sync2_reg <= '1;
        end else begin
            amt_sync1_reg <= bus.amount_ni;
            amt_sync2_reg <= amt_sync1_reg;
        end
    end

    logic              coin_ev, cancel_ev;
    logic [N_PROD-1:0] sel_ev;
    logic [W-1:0]      coin_amt;
    assign coin_ev   = press_ev[0];
    assign sel_ev    = press_ev[N_PROD:1];
    assign cancel_ev = press_ev[NB-1];
    assign coin_amt  = ~amt_sync2_reg;

    state_t            state_reg;
    logic [W-1:0]      credit_reg;
    logic [W-1:0]      change_reg;
    logic              change_valid_reg;
    logic              reject_reg;
    logic              short_reg;
    logic              busy_reg;
    logic [N_PROD-1:0] dispense_reg;
    logic [DCW-1:0]    disp_cnt_reg;

    // Extra top bit catches overflow instead of wrapping.
    logic [W:0] sum;
    assign sum = {1'b0, credit_reg} + {1'b0, coin_amt};

    // Lowest-index select event wins.
    logic [N_PROD-1:0] win_onehot;
    logic [W-1:0]      win_price;
    logic              win_found;
    always_comb begin
        win_onehot = '0;
        win_price  = '0;
        win_found  = 1'b0;
        for (int k = 0; k < N_PROD; k++) begin
            if (sel_ev[k] && !win_found) begin
                win_found     = 1'b1;
                win_onehot[k] = 1'b1;
                win_price     = bus.prices_i[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg        <= IDLE;
            credit_reg       <= '0;
            change_reg       <= '0;
            change_valid_reg <= 1'b0;
            reject_reg       <= 1'b0;
            short_reg        <= 1'b0;
            busy_reg         <= 1'b0;
            dispense_reg     <= '0;
            disp_cnt_reg     <= '0;
        end else begin
            reject_reg <= 1'b0;
            short_reg  <= 1'b0;
            case (state_reg)
                IDLE, ACCUM: begin
                    if (cancel_ev) begin
                        change_reg       <= credit_reg;
                        change_valid_reg <= 1'b1;
                        credit_reg       <= '0;
                        busy_reg         <= 1'b1;
                        state_reg        <= CHANGE;
                    end else if (coin_ev) begin
                        if (sum[W]) begin
                            reject_reg <= 1'b1;
                        end else begin
                            credit_reg <= sum[W-1:0];
                            state_reg  <= ACCUM;
                        end
                    end else if (win_found) begin
                        if (credit_reg >= win_price) begin
                            dispense_reg <= win_onehot;
                            credit_reg   <= credit_reg - win_price;
                            disp_cnt_reg <= '0;
                            busy_reg     <= 1'b1;
                            state_reg    <= VEND;
                        end else begin
                            short_reg <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    if (coin_ev) reject_reg <= 1'b1;
                    if (disp_cnt_reg == DCW'(DISP_CYCLES - 1)) begin
                        dispense_reg     <= '0;
                        change_reg       <= credit_reg;
                        change_valid_reg <= 1'b1;
                        credit_reg       <= '0;
                        state_reg        <= CHANGE;
                    end else begin
                        disp_cnt_reg <= disp_cnt_reg + 1'b1;
                    end
                end
                CHANGE: begin
                    if (coin_ev) reject_reg <= 1'b1;
                    change_reg       <= '0;
                    change_valid_reg <= 1'b0;
                    busy_reg         <= 1'b0;
                    state_reg        <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.dispense_o     = dispense_reg;
    assign bus.credit_o       = credit_reg;
    assign bus.change_o       = change_reg;
    assign bus.change_valid_o = change_valid_reg;
    assign bus.reject_o       = reject_reg;
    assign bus.short_o        = short_reg;
    assign bus.busy_o         = busy_reg;
endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench for vending_machine_multi (W=8, 4 products,
// debounce 4, dispense 8, prices 60/100/150/200).
module tb_vending_machine_multi;
    localparam int EV_DISP  = 1;
    localparam int EV_CHG   = 2;
    localparam int EV_REJ   = 3;
    localparam int EV_SHORT = 4;

    typedef struct {
        int         kind;
        logic [7:0] val;
        int         len;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    vending_machine_multi_if #(.W(8), .N_PROD(4)) bus ();

    vending_machine_multi #(
        .W(8), .N_PROD(4), .DEBOUNCE_CYCLES(4), .DISP_CYCLES(8)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    int price [4] = '{60, 100, 150, 200};
    int checks   = 0;
    int failures = 0;
    int model_credit = 0;
    exp_t q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input int val, input int len);
        exp_t e;
        e.kind = kind;
        e.val  = 8'(val);
        e.len  = len;
        q.push_back(e);
    endtask

    task automatic report(input int kind, input logic [7:0] val, input int len);
        exp_t e;
        $display("event kind=%0d val=%0d len=%0d t=%0t", kind, val, len, $time);
        check("sb_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
            e = q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_val", val, e.val);
            check("ev_len", len, e.len);
        end
    endtask

    // Output monitor: every strobe is matched against the scoreboard.
    int         disp_len = 0;
    logic [3:0] disp_val = '0;
    always @(negedge clk) begin
        if (!rst_ni) begin
            disp_len = 0;
        end else begin
            if (bus.dispense_o != 0) begin
                if (disp_len == 0) disp_val = bus.dispense_o;
                disp_len++;
            end else if (disp_len != 0) begin
                report(EV_DISP, {4'b0, disp_val}, disp_len);
                disp_len = 0;
            end
            if (bus.change_valid_o) report(EV_CHG, bus.change_o, 0);
            else check("change_zero", bus.change_o, 0);
            if (bus.reject_o) report(EV_REJ, 8'd0, 0);
            if (bus.short_o)  report(EV_SHORT, 8'd0, 0);
        end
    end

    task automatic release_all();
        bus.coin_ni   = 1'b1;
        bus.sel_ni    = 4'hF;
        bus.cancel_ni = 1'b1;
        bus.amount_ni = 8'hFF;
    endtask

    task automatic press(input logic c, input logic [7:0] amt, input logic [3:0] sel, input logic can);
        @(posedge clk); #2;
        bus.amount_ni = ~amt;
        bus.coin_ni   = ~c;
        bus.sel_ni    = ~sel;
        bus.cancel_ni = ~can;
        repeat (10) @(posedge clk);
        #2 release_all();
        repeat (10) @(posedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain", q.size(), 0);
    endtask

    task automatic do_coin(input int amt);
        if (model_credit + amt > 255) push(EV_REJ, 0, 0);
        else model_credit += amt;
        press(1'b1, 8'(amt), 4'h0, 1'b0);
        drain();
        check("credit_coin", bus.credit_o, model_credit);
    endtask

    task automatic do_select(input logic [3:0] mask);
        int k = 0;
        while (!mask[k]) k++;
        if (model_credit >= price[k]) begin
            push(EV_DISP, 1 << k, 8);
            push(EV_CHG, model_credit - price[k], 0);
            model_credit = 0;
        end else begin
            push(EV_SHORT, 0, 0);
        end
        press(1'b0, 8'd0, mask, 1'b0);
        drain();
        check("credit_sel", bus.credit_o, model_credit);
    endtask

    task automatic do_cancel();
        push(EV_CHG, model_credit, 0);
        model_credit = 0;
        press(1'b0, 8'd0, 4'h0, 1'b1);
        drain();
        check("credit_cancel", bus.credit_o, 0);
    endtask

    initial begin
        rst_ni = 1'b0;
        release_all();
        bus.prices_i = {8'd200, 8'd150, 8'd100, 8'd60};
        repeat (3) @(negedge clk);
        check("rst_credit", bus.credit_o, 0);
        check("rst_dispense", bus.dispense_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_strobes", {bus.change_valid_o, bus.reject_o, bus.short_o}, 0);
        @(posedge clk); #2 rst_ni = 1'b1;

        // 50 + 50, buy product 1, zero change
        do_coin(50);
        do_coin(50);
        do_select(4'b0010);
        // 110, buy product 0, change 50
        do_coin(110);
        do_select(4'b0001);
        // overflow reject, then cancel refunds 200
        do_coin(100);
        do_coin(100);
        do_coin(100);
        do_cancel();
        // short credit, then simultaneous selects 2 and 3
        do_coin(50);
        do_select(4'b0100);
        do_coin(150);
        do_select(4'b1100);
        // select with no credit, zero-value coin
        do_select(4'b0001);
        do_coin(0);

        // bouncing coin then held: one increment
        @(posedge clk); #2 bus.amount_ni = ~8'd30;
        for (int i = 0; i < 5; i++) begin
            bus.coin_ni = 1'b0; repeat (2) @(posedge clk); #2;
            bus.coin_ni = 1'b1; repeat (2) @(posedge clk); #2;
        end
        bus.coin_ni = 1'b0;
        repeat (10) @(posedge clk);
        #2 release_all();
        repeat (10) @(posedge clk);
        model_credit = 30;
        drain();
        check("credit_bounce", bus.credit_o, 30);
        do_cancel();

        // coin arrives while dispensing: rejected
        do_coin(100);
        push(EV_REJ, 0, 0);
        push(EV_DISP, 1, 8);
        push(EV_CHG, 40, 0);
        model_credit = 0;
        @(posedge clk); #2 bus.sel_ni = 4'b1110;
        repeat (3) @(posedge clk);
        #2 bus.amount_ni = ~8'd20; bus.coin_ni = 1'b0;
        repeat (10) @(posedge clk);
        #2 release_all();
        repeat (10) @(posedge clk);
        drain();
        check("credit_vend_coin", bus.credit_o, 0);

        // cancel and coin in the same cycle: cancel wins, coin discarded
        push(EV_CHG, 0, 0);
        press(1'b1, 8'd50, 4'h0, 1'b1);
        drain();
        check("credit_cancel_coin", bus.credit_o, 0);

        // reset during dispense
        do_coin(100);
        @(posedge clk); #2 bus.sel_ni = 4'b1110;
        begin
            int n = 0;
            while (bus.dispense_o == 0 && n < 40) begin @(negedge clk); n++; end
            check("vend_started", bus.dispense_o, 4'b0001);
        end
        check("credit_in_vend", bus.credit_o, 40);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_vend_dispense", bus.dispense_o, 0);
        check("rst_vend_credit", bus.credit_o, 0);
        check("rst_vend_busy", bus.busy_o, 0);
        q.delete();
        model_credit = 0;
        release_all();
        repeat (3) @(posedge clk);
        #2 rst_ni = 1'b1;
        repeat (20) @(negedge clk);
        check("no_change_after_rst", q.size(), 0);

        // button held through reset release: full debounce before event
        rst_ni = 1'b0;
        bus.amount_ni = ~8'd10;
        bus.coin_ni   = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        check("held_early", bus.credit_o, 0);
        repeat (12) @(negedge clk);
        check("held_late", bus.credit_o, 10);
        model_credit = 10;
        #2 release_all();
        repeat (10) @(posedge clk);
        do_cancel();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
